// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: sends a command byte (+ optional argument) and waits for the 0xFA ack.
// Optional resend handling on 0xFE is enabled by defining PS2_RESEND_RETRY_EN.
module ps2_host_cmd_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15,
  parameter int RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_gate,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_code
);

  localparam longint INH_L   = (longint'(INHIBIT_US) * longint'(CLK_HZ)) / 1000000;
  localparam longint TO_L    = (longint'(TIMEOUT_MS) * longint'(CLK_HZ)) / 1000;
  localparam int     INH_CYC = (INH_L < 1) ? 1 : int'(INH_L);
  localparam int     TO_CYC  = (TO_L < 1) ? 1 : int'(TO_L);
  localparam int     TMR_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int     TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] INH_LOAD = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYC - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_TX        = 3'd3;
  localparam logic [2:0] S_ACKBIT    = 3'd4;
  localparam logic [2:0] S_WAIT_RESP = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_RESEND  = 3'd2;
  localparam logic [2:0] ERR_NOACK   = 3'd3;
  localparam logic [2:0] ERR_UNEXP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic          arg_phase_q, arg_phase_d;
  logic          data_oe_q, data_oe_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          ps2_fall, ps2_data_s, tmo;

`ifdef PS2_RESEND_RETRY_EN
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // [0],[1] synchronize, [2] is the previous synced sample for edge detect
  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
  end

  assign ps2_fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];
  assign tmo        = (tmr_q == '0);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    has_arg_d   = has_arg_q;
    arg_phase_d = arg_phase_q;
    data_oe_d   = data_oe_q;
    err_code_d  = err_code_q;
`ifdef PS2_RESEND_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d       = cmd_byte;
          arg_d       = cmd_arg;
          has_arg_d   = cmd_has_arg;
          arg_phase_d = 1'b0;
          err_code_d  = 3'd0;
          sh_d        = frame_of(cmd_byte);
`ifdef PS2_RESEND_RETRY_EN
          retry_d     = '0;
`endif
          state_d     = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmo) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end
      end
      S_RTS: state_d = S_TX;
      S_TX: begin
        if (ps2_fall) begin
          data_oe_d = ~sh_q[0];
          sh_d      = {1'b0, sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = S_ACKBIT;
        end else if (tmo) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERROR;
        end
      end
      S_ACKBIT: begin
        if (ps2_fall) begin
          if (!ps2_data_s) begin
            state_d = S_WAIT_RESP;
          end else begin
            err_code_d = ERR_NOACK;
            state_d    = S_ERROR;
          end
        end else if (tmo) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERROR;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            if (has_arg_q && !arg_phase_q) begin
              arg_phase_d = 1'b1;
              sh_d        = frame_of(arg_q);
`ifdef PS2_RESEND_RETRY_EN
              retry_d     = '0;
`endif
              state_d     = S_INHIBIT;
            end else begin
              state_d = S_DONE;
            end
          end else if (rx_byte == 8'hFE) begin
`ifdef PS2_RESEND_RETRY_EN
            if (retry_q == RW'(RETRIES)) begin
              err_code_d = ERR_RESEND;
              state_d    = S_ERROR;
            end else begin
              retry_d = retry_q + 1'b1;
              sh_d    = frame_of(arg_phase_q ? arg_q : cmd_q);
              state_d = S_INHIBIT;
            end
`else
            err_code_d = ERR_RESEND;
            state_d    = S_ERROR;
`endif
          end else begin
            err_code_d = ERR_UNEXP;
            state_d    = S_ERROR;
          end
        end else if (tmo) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_RTS && state_d != S_TX) data_oe_d = 1'b0;
    if (state_d == S_INHIBIT) bit_cnt_d = '0;

    // One down-counter serves both the inhibit interval and the event timeout
    if (state_d != state_q)
      tmr_d = (state_d == S_INHIBIT) ? INH_LOAD : TO_LOAD;
    else if (ps2_fall && state_q != S_INHIBIT && state_q != S_IDLE)
      tmr_d = TO_LOAD;
    else if (!tmo)
      tmr_d = tmr_q - 1'b1;
    else
      tmr_d = tmr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      has_arg_q   <= 1'b0;
      arg_phase_q <= 1'b0;
      data_oe_q   <= 1'b0;
      err_code_q  <= 3'd0;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
`ifdef PS2_RESEND_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      has_arg_q   <= has_arg_d;
      arg_phase_q <= arg_phase_d;
      data_oe_q   <= data_oe_d;
      err_code_q  <= err_code_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
`ifdef PS2_RESEND_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_oe = data_oe_q;
  assign rx_gate     = (state_q == S_INHIBIT) || (state_q == S_RTS) ||
                       (state_q == S_TX) || (state_q == S_ACKBIT);
  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: open-drain PS/2 device model, directed test-plan cases plus random
// transaction scripts checked against a transaction-level outcome model.
module tb_ps2_host_cmd_ctrl;
  localparam int CLK_HZ     = 1000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_MS = 2;
  localparam int RETRIES    = 2;
  localparam int INH_CYC    = INHIBIT_US * CLK_HZ / 1000000;
  localparam int TO_CYC     = TIMEOUT_MS * CLK_HZ / 1000;
  localparam int HP         = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_has_arg = 1'b0;
  logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00, rx_byte = 8'h00;
  logic       rx_valid = 1'b0, rx_gate, busy, done, error;
  logic [2:0] err_code;
  logic       dev_clk_lo = 1'b0, dev_data_lo = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

  ps2_host_cmd_ctrl #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS), .RETRIES(RETRIES)) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_gate(rx_gate), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
  int scr_kind[$];
  logic [7:0] scr_resp[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 normal ack, 1 data left high at ack edge, 2 ack but no response, 3 never clocks
  task automatic dev_frame(input int kind, input bit abort4, output logic [10:0] frame,
                           output int inh, output bit req);
    int n, ji;
    frame = '0; inh = 0; req = 1'b0; n = 0;
    ji = $urandom_range(0, 9);
    while (!ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) return;
    req = 1'b1;
    check_eq("rx_gate_inhibit", 32'(rx_gate), 32'd1);
    while (ps2_clk_oe && inh < 5000) begin @(negedge clk); inh++; end
    frame[0] = ps2_data_in;
    if (kind == 3) return;
    for (int i = 0; i < 10; i++) begin
      repeat (HP) @(negedge clk);
      dev_clk_lo = 1'b1;
      if (abort4 && i == 4) begin
        repeat (6) @(negedge clk);
        return;
      end
      repeat (HP - 1) @(negedge clk);
      if (i == ji) begin
        rx_byte   = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'($urandom);
        rx_valid  = 1'b1;
        cmd_byte  = 8'($urandom);
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid  = 1'b0;
      cmd_valid = 1'b0;
      frame[i+1] = ps2_data_in;
      dev_clk_lo = 1'b0;
    end
    repeat (HP) @(negedge clk);
    dev_data_lo = (kind != 1);
    repeat (HP) @(negedge clk);
    dev_clk_lo = 1'b1;
    repeat (HP) @(negedge clk);
    dev_clk_lo = 1'b0;
    repeat (HP) @(negedge clk);
    dev_data_lo = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    repeat (10) @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] c, input bit ha, input logic [7:0] a, input string nm);
    logic [10:0] frame;
    logic [7:0]  exp_b;
    int inh, base_done, base_err, n, t0, pos, retries, exp_err, last_kind, lat;
    bit req, finished, exp_done, seen;
    @(negedge clk);
    base_done = done_cnt; base_err = err_cnt;
    exp_err = 0; exp_done = 0; pos = 0; retries = 0; finished = 0; last_kind = 0; t0 = 0;
    check_eq({nm, ":idle_ready"}, 32'(cmd_ready), 32'd1);
    cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq({nm, ":accept"}, 32'({cmd_ready, busy}), 32'b01);
    for (int k = 0; k < scr_kind.size() && !finished; k++) begin
      exp_b = (pos == 1) ? a : c;
      last_kind = scr_kind[k];
      dev_frame(scr_kind[k], 1'b0, frame, inh, req);
      check_eq({nm, ":req"}, 32'(req), 32'd1);
      if (!req) begin
        finished = 1;
      end else begin
        check_eq({nm, ":inhibit_len"}, 32'(inh), 32'(INH_CYC + 1));
        if (scr_kind[k] == 3) begin
          t0 = cyc; exp_err = 1; finished = 1;
        end else begin
          check_eq({nm, ":frame"}, 32'(frame), 32'({1'b1, ~^exp_b, exp_b, 1'b0}));
          if (scr_kind[k] == 1) begin
            exp_err = 3; finished = 1;
          end else begin
            check_eq({nm, ":rx_gate_resp"}, 32'(rx_gate), 32'd0);
            if (scr_kind[k] == 2) begin
              exp_err = 1; finished = 1;
            end else begin
              send_rx(scr_resp[k]);
              if (scr_resp[k] == 8'hFA) begin
                if (pos == 0 && ha) begin pos = 1; retries = 0; end
                else begin exp_done = 1; finished = 1; end
              end else if (scr_resp[k] == 8'hFE) begin
`ifdef PS2_RESEND_RETRY_EN
                if (retries == RETRIES) begin exp_err = 2; finished = 1; end
                else retries++;
`else
                exp_err = 2; finished = 1;
`endif
              end else begin
                exp_err = 4; finished = 1;
              end
            end
          end
        end
      end
    end
    n = 0;
    while ((done_cnt - base_done) + (err_cnt - base_err) == 0 && n < TO_CYC + 200) begin
      @(negedge clk); n++;
    end
    check_eq({nm, ":completes"}, 32'(n < TO_CYC + 200), 32'd1);
    repeat (3) @(negedge clk);
    check_eq({nm, ":done_pulses"}, 32'(done_cnt - base_done), 32'(exp_done));
    check_eq({nm, ":err_pulses"}, 32'(err_cnt - base_err), 32'(exp_err != 0));
    check_eq({nm, ":err_code"}, 32'(err_code), 32'(exp_err));
    check_eq({nm, ":idle_lines"}, 32'({ps2_clk_oe, ps2_data_oe, cmd_ready, busy}), 32'b0010);
    if (last_kind == 3) begin
      lat = err_cyc - t0;
      check_eq({nm, ":timeout_latency"}, 32'((lat == TO_CYC || lat == TO_CYC + 1) ? TO_CYC : lat), 32'(TO_CYC));
    end
    seen = 0;
    repeat (INH_CYC + 20) begin
      @(negedge clk);
      if (ps2_clk_oe) seen = 1;
    end
    check_eq({nm, ":no_extra_req"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] frame;
    logic [7:0]  b;
    int inh, r, kind;
    bit req;

    repeat (4) @(negedge clk);
    check_eq("rst_hold", 32'({ps2_clk_oe, ps2_data_oe, cmd_ready, rx_gate, busy, done, error}), 32'b0010000);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_outputs", 32'({ps2_clk_oe, ps2_data_oe, cmd_ready, rx_gate, busy, done, error}), 32'b0010000);
    check_eq("rst_err_code", 32'(err_code), 32'd0);

    scr_kind = '{0};       scr_resp = '{8'hFA};              run_txn(8'hFF, 1'b0, 8'h00, "reset_cmd");
    scr_kind = '{0, 0};    scr_resp = '{8'hFA, 8'hFA};       run_txn(8'hED, 1'b1, 8'h02, "leds");
    scr_kind = '{3};       scr_resp = '{8'hFA};              run_txn(8'hF2, 1'b0, 8'h00, "no_clock");
    scr_kind = '{1};       scr_resp = '{8'hFA};              run_txn(8'hF4, 1'b0, 8'h00, "no_ack");
    scr_kind = '{0, 0, 0}; scr_resp = '{8'hFE, 8'hFE, 8'hFA}; run_txn(8'hF3, 1'b0, 8'h00, "resend");
    scr_kind = '{0};       scr_resp = '{8'hAA};              run_txn(8'hEE, 1'b0, 8'h00, "unexpected");
    scr_kind = '{2};       scr_resp = '{8'hFA};              run_txn(8'hF5, 1'b0, 8'h00, "resp_timeout");

    // asynchronous reset while bit 4 of 0xEE (a 0, so data is pulled) is on the bus
    @(negedge clk);
    cmd_byte = 8'hEE; cmd_has_arg = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    dev_frame(0, 1'b1, frame, inh, req);
    check_eq("rst_mid:data_driven", 32'(ps2_data_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid:released", 32'({ps2_clk_oe, ps2_data_oe, cmd_ready, busy}), 32'b0010);
    dev_clk_lo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scr_kind = '{0, 0}; scr_resp = '{8'hFA, 8'hFA}; run_txn(8'hF3, 1'b1, 8'h2B, "after_rst");

    for (int t = 0; t < 12; t++) begin
      scr_kind.delete();
      scr_resp.delete();
      for (int s = 0; s < 7; s++) begin
        r = $urandom_range(0, 29);
        kind = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
        r = $urandom_range(0, 9);
        if (r < 6) b = 8'hFA;
        else if (r < 9) b = 8'hFE;
        else begin
          b = 8'($urandom);
          if (b == 8'hFA || b == 8'hFE) b = 8'h55;
        end
        scr_kind.push_back(kind);
        scr_resp.push_back(b);
      end
      run_txn(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_host_cmd_ctrl.md
Name: ps2_host_cmd_ctrl

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port.
- Drives the shared PS/2 clock/data lines open-drain to send a command byte plus an optional argument (e.g. 0xED + LED mask, 0xFF reset, 0xF3 + typematic rate).
- Waits for the 0xFA acknowledge from the keyboard via the existing byte receiver.
- Gates that receiver while the host owns the bus, so host-driven clocks are never decoded as scan codes.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- INHIBIT_US, 100, clock-low inhibit time before request-to-send, in µs.
- TIMEOUT_MS, 15, max gap between PS/2 events or before the response byte, in ms.
- RETRIES, 2, max retransmissions on 0xFE (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle, accepts command
- cmd_byte  in  8  command byte
- cmd_has_arg  in  1  an argument byte follows the command
- cmd_arg  in  8  argument byte
- rx_valid  in  1  one-cycle strobe from byte receiver, complete byte available
- rx_byte  in  8  received byte
- rx_gate  out  1  1 = byte receiver must ignore the bus
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse, transaction completed OK
- error  out  1  one-cycle pulse, transaction failed
- err_code  out  3  cause of the last error, held until the next accepted command

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, cmd_ready=1, rx_gate=0, busy=0, done=0, error=0, err_code=0, state IDLE.
- Reset mid-transaction: both lines released immediately (asynchronous).
- Input sync and edge detect:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
  - Falling edge = previous synced value 1, current synced value 0.
  - Edge detect adds 3 cycles of latency, negligible against the 10-16.7 kHz PS/2 clock.
- Accept: cmd_valid && cmd_ready in IDLE latches cmd_byte, cmd_has_arg, cmd_arg; clears err_code and the retry count; cmd_ready drops on the next cycle.
- Command arriving while busy: ignored; the requester must hold it until cmd_ready.
- Shift register: 10 bits = {stop=1, odd parity, data[7:0]}, sent LSB first. Odd parity = ~^data.
- States:
  - IDLE: lines released; busy=0.
  - INHIBIT: clk_oe=1, rx_gate=1, for INHIBIT_US×CLK_HZ/1e6 cycles; then data_oe=1 (start bit) and go to RTS.
  - RTS: data_oe held 1, clk_oe=1 for one more cycle, then clk_oe=0 and go to TX.
  - TX: on each ps2 clock falling edge, drive the next shift-register bit (data_oe = ~bit); bit counter 0..9. The edge after bit 9 (stop bit, released) goes to ACKBIT.
  - ACKBIT: data released; on the next falling edge, sample synced data. 0 → WAIT_RESP with rx_gate=0. 1 → ERROR, code 3.
  - WAIT_RESP, on rx_valid:
    - 0xFA: go to INHIBIT with the arg loaded if has_arg is set and the arg is not yet sent, otherwise DONE.
    - 0xFE: see Optional Feature.
    - Any other byte: ERROR, code 4.
  - DONE: done=1 for one cycle, then IDLE.
  - ERROR: error=1 for one cycle, both lines released, then IDLE.
- Timeout: counter of TIMEOUT_MS×CLK_HZ/1000 cycles. Reloads on every state entry and every ps2 falling edge. Runs in RTS, TX, ACKBIT and WAIT_RESP. Expiry → ERROR, code 1.
- err_code values: 0 none, 1 timeout, 2 resend refused/exhausted, 3 no ack bit, 4 unexpected response.
- rx_valid outside WAIT_RESP is ignored; those bytes are ordinary scan codes for other consumers.
- Simultaneous timeout expiry and falling edge or rx_valid in the same cycle: the event wins.
- busy = (state != IDLE); cmd_ready = (state == IDLE).

Optional Feature:
- Macro PS2_RESEND_RETRY_EN.
- Defined:
  - 0xFE in WAIT_RESP re-enters INHIBIT and retransmits the same byte (command or arg); retry count +1.
  - 0xFE received when the count already equals RETRIES → ERROR, code 2.
  - The count resets when the next byte starts and on command accept.
- Undefined: 0xFE → ERROR, code 2 immediately; no retry counter logic, and RETRIES is unused.

Test Plan:
- Send 0xFF, no arg; device model clocks 11 edges, acks with data low, then rx 0xFA.
  - clk_oe low ≥5000 cycles at 50 MHz.
  - Bits observed: 1,1,1,1,1,1,1,1, parity 1, stop 1.
  - done pulses once; err_code=0.
- Send 0xED with arg 0x02; device acks both bytes with 0xFA.
  - Two full frames; second frame data 0x02, parity 0.
  - done pulses only after the second 0xFA.
- Device never clocks after the request-to-send → error after 15 ms (750000 cycles); err_code=1; both oe=0.
- Device leaves data high at the ack edge → error, err_code=3.
- Device responds 0xFE, 0xFE, 0xFA:
  - With the macro and RETRIES=2: the byte is sent 3 times, then done.
  - Without the macro: error after the first 0xFE, err_code=2.
- Assert rst during TX bit 4 → ps2_clk_oe=0, ps2_data_oe=0, cmd_ready=1 immediately; a new command afterwards completes normally.
